// File: rtl/viterbi_pkg.sv
// Shared helpers for the Viterbi ACS array: code-bit parity, soft branch cost,
// trellis predecessor indexing, start-of-frame metric and saturating metric add.
package viterbi_pkg;

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

    // Distance of a signed soft value from the ideal level of code bit c.
    function automatic int branch_cost(input logic c, input int r, input int sw);
        int half;
        half = 1 << (sw - 1);
        return c ? (half - 1 - r) : (r + half);
    endfunction

    // Predecessor p_b of next state ns: shift ns up one place, append b.
    function automatic int pred_idx(input int ns, input int b, input int k);
        return ((ns << 1) | b) & ((1 << (k - 1)) - 1);
    endfunction

    function automatic int init_big(input int pmw);
        return 1 << (pmw - 2);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int pmw);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << pmw) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/viterbi_acs_cell.sv
// One add-compare-select cell: extends both predecessor metrics by their branch
// metrics and keeps the smaller; ties keep predecessor p0.
module viterbi_acs_cell
    import viterbi_pkg::*;
#(
    parameter int SW  = 8,
    parameter int PMW = 12
) (
    input  logic [PMW-1:0] pm0,
    input  logic [PMW-1:0] pm1,
    input  logic [SW:0]    bm0,
    input  logic [SW:0]    bm1,
    output logic [PMW-1:0] pm_sel,
    output logic           dec
);

    logic [31:0] cand0;
    logic [31:0] cand1;

    always_comb begin
        cand0  = sat_add(32'(pm0), 32'(bm0), PMW);
        cand1  = sat_add(32'(pm1), 32'(bm1), PMW);
        dec    = (cand1 < cand0);
        pm_sel = dec ? cand1[PMW-1:0] : cand0[PMW-1:0];
    end

endmodule

// File: rtl/viterbi_acs_array.sv
// Single-cycle ACS engine for a rate-1/2 Viterbi decoder: all 2^(K-1) states
// advance per accepted symbol, followed by min/argmin and metric normalisation.
module viterbi_acs_array
    import viterbi_pkg::*;
#(
    parameter int             K   = 3,
    parameter int             SW  = 8,
    parameter int             PMW = 12,
    parameter logic [K-1:0]   G0  = 3'b111,
    parameter logic [K-1:0]   G1  = 3'b101,
    localparam int            N   = 1 << (K - 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             init,
    input  logic             in_valid,
    input  logic [SW-1:0]    r0,
    input  logic [SW-1:0]    r1,
    output logic             out_valid,
    output logic [N-1:0]     decisions,
    output logic [K-2:0]     best_state,
    output logic [PMW-1:0]   norm_amount,
    output logic [N*PMW-1:0] pm_out
);

    typedef logic [K-2:0] st_t;

    logic [PMW-1:0] pm_q [N];
    logic [PMW-1:0] pm_d [N];
    logic [PMW-1:0] pm_base [N];
    logic [PMW-1:0] pm_sel [N];
    logic [PMW-1:0] cell_pm0 [N];
    logic [PMW-1:0] cell_pm1 [N];
    logic [SW:0]    cell_bm0 [N];
    logic [SW:0]    cell_bm1 [N];
    logic [SW:0]    bm_tab [4];
    logic [N-1:0]   dec_w, dec_q, dec_d;
    st_t            best_w, best_q, best_d;
    logic [PMW-1:0] mn, norm_q, norm_d;
    logic           out_valid_q, out_valid_d;

    function automatic logic [PMW-1:0] reset_pm(input int s);
        return (s == 0) ? '0 : PMW'(init_big(PMW));
    endfunction

    // bm_tab is indexed by {c0, c1}; only four distinct branch metrics exist per symbol.
    always_comb begin
        int sr0, sr1, p0i, p1i, u, w0, w1;
        sr0 = int'(signed'(r0));
        sr1 = int'(signed'(r1));
        p0i = 0;
        p1i = 0;
        u   = 0;
        w0  = 0;
        w1  = 0;
        for (int i = 0; i < 4; i++) begin
            bm_tab[i] = (SW+1)'(branch_cost(i[1], sr0, SW) + branch_cost(i[0], sr1, SW));
        end
        for (int s = 0; s < N; s++) begin
            pm_base[s] = init ? reset_pm(s) : pm_q[s];
        end
        for (int ns = 0; ns < N; ns++) begin
            p0i = pred_idx(ns, 0, K);
            p1i = pred_idx(ns, 1, K);
            u   = (ns >> (K - 2)) & 1;
            w0  = (u << (K - 1)) | p0i;
            w1  = (u << (K - 1)) | p1i;
            cell_pm0[ns] = pm_base[st_t'(p0i)];
            cell_pm1[ns] = pm_base[st_t'(p1i)];
            cell_bm0[ns] = bm_tab[{parity(w0 & 32'(G0)), parity(w0 & 32'(G1))}];
            cell_bm1[ns] = bm_tab[{parity(w1 & 32'(G0)), parity(w1 & 32'(G1))}];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cell
        viterbi_acs_cell #(.SW(SW), .PMW(PMW)) u_cell (
            .pm0    (cell_pm0[g]),
            .pm1    (cell_pm1[g]),
            .bm0    (cell_bm0[g]),
            .bm1    (cell_bm1[g]),
            .pm_sel (pm_sel[g]),
            .dec    (dec_w[g])
        );
        assign pm_out[g*PMW +: PMW] = pm_q[g];
    end

    // Strict compare keeps the lowest index among equal minima.
    always_comb begin
        mn     = pm_sel[0];
        best_w = '0;
        for (int s = 1; s < N; s++) begin
            if (pm_sel[s] < mn) begin
                mn     = pm_sel[s];
                best_w = st_t'(s);
            end
        end
    end

    always_comb begin
        out_valid_d = in_valid;
        dec_d       = dec_q;
        best_d      = best_q;
        norm_d      = norm_q;
        for (int s = 0; s < N; s++) begin
            pm_d[s] = pm_base[s];
        end
        if (in_valid) begin
            dec_d  = dec_w;
            best_d = best_w;
            norm_d = mn;
            for (int s = 0; s < N; s++) begin
                pm_d[s] = pm_sel[s] - mn;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            best_q      <= '0;
            norm_q      <= '0;
            for (int s = 0; s < N; s++) begin
                pm_q[s] <= reset_pm(s);
            end
        end else begin
            out_valid_q <= out_valid_d;
            dec_q       <= dec_d;
            best_q      <= best_d;
            norm_q      <= norm_d;
            for (int s = 0; s < N; s++) begin
                pm_q[s] <= pm_d[s];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign decisions   = dec_q;
    assign best_state  = best_q;
    assign norm_amount = norm_q;

endmodule

// File: tb/tb_viterbi_acs_array.sv
// Randomised scoreboard bench for viterbi_acs_array (K=3, SW=8, PMW=12, G=7/5)
// against a forward-enumerating trellis model.
module tb_viterbi_acs_array;

    localparam int BIG   = 1024;
    localparam int MAXPM = 4095;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        init = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  r0 = '0;
    logic [7:0]  r1 = '0;
    logic        out_valid;
    logic [3:0]  decisions;
    logic [1:0]  best_state;
    logic [11:0] norm_amount;
    logic [47:0] pm_out;

    viterbi_acs_array #(.K(3), .SW(8), .PMW(12), .G0(3'b111), .G1(3'b101)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .init        (init),
        .in_valid    (in_valid),
        .r0          (r0),
        .r1          (r1),
        .out_valid   (out_valid),
        .decisions   (decisions),
        .best_state  (best_state),
        .norm_amount (norm_amount),
        .pm_out      (pm_out)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  dec;
        logic [1:0]  best;
        logic [11:0] norm;
        logic [47:0] pm;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         mpm[4];
    logic [3:0] last_dec = '0;
    logic [1:0] last_best = '0;
    localparam logic [47:0] RESET_PM = {12'd1024, 12'd1024, 12'd1024, 12'd0};

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int cost(input int c, input int r);
        return (c != 0) ? (127 - r) : (r + 128);
    endfunction

    task automatic model_reset();
        mpm[0] = 0;
        for (int s = 1; s < 4; s++) mpm[s] = BIG;
    endtask

    // Walk every (old state, input bit) edge of the encoder; keep the best edge per new state.
    task automatic model_step(input bit ini, input bit v, input int a, input int b);
        int   base[4];
        int   cand[4][2];
        int   nv[4];
        int   mn, bi, ns, wd, c0, c1, c;
        exp_t e;
        if (ini) model_reset();
        if (!v) return;
        for (int s = 0; s < 4; s++) base[s] = mpm[s];
        for (int p = 0; p < 4; p++) begin
            for (int u = 0; u < 2; u++) begin
                ns = u * 2 + p / 2;
                wd = u * 4 + p;
                c0 = $countones(wd & 7) % 2;
                c1 = $countones(wd & 5) % 2;
                c  = base[p] + cost(c0, a) + cost(c1, b);
                if (c > MAXPM) c = MAXPM;
                cand[ns][p % 2] = c;
            end
        end
        mn = 1 << 30;
        bi = 0;
        e  = '0;
        for (int s = 0; s < 4; s++) begin
            e.dec[s] = (cand[s][1] < cand[s][0]);
            nv[s]    = e.dec[s] ? cand[s][1] : cand[s][0];
            if (nv[s] < mn) begin
                mn = nv[s];
                bi = s;
            end
        end
        for (int s = 0; s < 4; s++) begin
            mpm[s] = nv[s] - mn;
            e.pm[s*12 +: 12] = 12'(mpm[s]);
        end
        e.best    = 2'(bi);
        e.norm    = 12'(mn);
        last_dec  = e.dec;
        last_best = e.best;
        sb.push_back(e);
    endtask

    task automatic drive(input bit ini, input bit v, input int a, input int b);
        @(negedge CLK);
        init     = ini;
        in_valid = v;
        r0       = 8'(a);
        r1       = 8'(b);
        model_step(ini, v, a, b);
    endtask

    function automatic int rnd_soft();
        case ($urandom_range(0, 7))
            0:       return -128;
            1:       return 127;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t e;
        int   mn;
        if (!RST && out_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output at %0t: got out_valid 1, expected no result", $time);
            end else begin
                e = sb.pop_front();
                chk("decisions", decisions, e.dec);
                chk("best_state", best_state, e.best);
                chk("norm_amount", norm_amount, e.norm);
                chk("pm_out", pm_out, e.pm);
                mn = MAXPM + 1;
                for (int s = 0; s < 4; s++)
                    if (int'(pm_out[s*12 +: 12]) < mn) mn = int'(pm_out[s*12 +: 12]);
                chk("pm_min_zero", mn, 0);
            end
        end
    end

    int path_a[4] = '{127, 127, -128, -128};
    int path_b[4] = '{127, -128, -128, 127};
    int path_best[4] = '{2, 1, 2, 3};

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_decisions", decisions, 0);
        chk("rst_best_state", best_state, 0);
        chk("rst_norm", norm_amount, 0);
        chk("rst_pm_out", pm_out, RESET_PM);

        // Init alone reloads metrics and leaves decisions/best_state alone.
        drive(0, 1, 50, -30);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_pm_out", pm_out, RESET_PM);
        chk("init_decisions_hold", decisions, last_dec);
        chk("init_best_hold", best_state, last_best);

        drive(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, path_a[i], path_b[i]);
            drive(0, 0, 0, 0);
            chk("path_best", best_state, path_best[i]);
            chk("path_norm", norm_amount, 0);
        end

        drive(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, -128, -128);
            drive(0, 0, 0, 0);
            chk("zero_best", best_state, 0);
            chk("zero_dec0", decisions[0], 0);
            chk("zero_pm0", pm_out[11:0], 0);
            for (int s = 1; s < 4; s++) chk("zero_pm_ge510", (pm_out[s*12 +: 12] >= 12'd510), 1);
        end

        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), rnd_soft(), rnd_soft());
        end

        for (int i = 0; i < 5; i++) drive(0, 1, rnd_soft(), rnd_soft());
        drive(1, 1, 127, 127);
        drive(0, 0, 0, 0);
        chk("restart_best", best_state, 2);
        chk("restart_pm2", pm_out[35:24], 0);

        for (int i = 0; i < 3; i++) drive(0, 1, rnd_soft(), rnd_soft());
        @(posedge CLK);
        #2;
        chk("burst_out_valid", out_valid, 1);
        RST      = 1'b1;
        in_valid = 1'b0;
        init     = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_decisions", decisions, 0);
        chk("async_rst_pm_out", pm_out, RESET_PM);
        sb.delete();
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 1, 127, 127);
        drive(0, 0, 0, 0);
        chk("post_rst_best", best_state, 2);
        chk("post_rst_pm2", pm_out[35:24], 0);

        repeat (3) drive(0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
